// File: rtl/priority_arbiter_pkg.sv
// Shared definitions for the priority arbiter: arbitration modes and FSM states.
package priority_arbiter_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    LOCK  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/priority_arbiter_prio_pick.sv
// Combinational winner search: highest index in fixed mode, or first set bit
// walking upward from start (with wrap) in round-robin mode.
module prio_pick
  import priority_arbiter_pkg::*;
#(
  parameter  int N  = 8,
  parameter  int RR = MODE_FIXED,
  localparam int W  = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  int p;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    p     = 0;
    if (RR == MODE_RR) begin
      // Walk the search order backwards so the earliest candidate overwrites last.
      for (int i = N - 1; i >= 0; i--) begin
        p = int'(start) + i;
        if (p >= N) p = p - N;
        if (req[W'(p)]) begin
          found = 1'b1;
          idx   = W'(p);
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req[W'(i)]) begin
          found = 1'b1;
          idx   = W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/priority_arbiter.sv
// Registered N-way priority arbiter (fixed or round-robin).
// Define PRIORITY_ARBITER_LOCK_EN to hold a grant while its requester stays asserted.
module priority_arbiter
  import priority_arbiter_pkg::*;
#(
  parameter  int N  = 8,
  parameter  int RR = MODE_FIXED,
  localparam int W  = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_valid
);

  arb_state_e   state;
  logic [W-1:0] ptr;
  logic         found;
  logic [W-1:0] pick_idx;
  logic [W-1:0] ptr_nxt;

  prio_pick #(.N(N), .RR(RR)) u_pick (
    .req   (req),
    .start (ptr),
    .found (found),
    .idx   (pick_idx)
  );

  // Explicit wrap keeps the pointer in range for non-power-of-two N.
  assign ptr_nxt   = (pick_idx == W'(N - 1)) ? '0 : pick_idx + 1'b1;
  assign gnt_valid = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt     <= '0;
      gnt_idx <= '0;
    end else if (en) begin
`ifdef PRIORITY_ARBITER_LOCK_EN
      if (gnt_valid && req[gnt_idx]) begin
        state <= LOCK;
      end else
`endif
      if (found) begin
        state   <= GRANT;
        gnt     <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
        gnt_idx <= pick_idx;
        if (RR == MODE_RR) ptr <= ptr_nxt;
      end else begin
        state   <= IDLE;
        gnt     <= '0;
        gnt_idx <= '0;
      end
    end
  end

endmodule

// File: doc/priority_arbiter.md
PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning number of request lines (legal range 2..32).
REQ-002 The block SHALL have parameter RR, default 0, meaning 0 = fixed priority and 1 = round-robin priority.
REQ-003 The block SHALL have derived localparam W = $clog2(N), meaning the grant index width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port req, input, N bits: request vector; bit k = requester k.
REQ-007 The block SHALL have port en, input, 1 bit: arbitration enable; when 0, all state holds.
REQ-008 The block SHALL have port gnt, output, N bits: registered one-hot grant, or all zeros.
REQ-009 The block SHALL have port gnt_idx, output, W bits: registered binary index of the granted line.
REQ-010 The block SHALL have port gnt_valid, output, 1 bit: registered flag, 1 when gnt is non-zero.

Function
REQ-011 Outputs SHALL be registered with 1-cycle latency: req sampled at edge t appears on gnt/gnt_idx/gnt_valid after edge t.
REQ-012 With RR=0, the highest-index asserted req bit SHALL win, matching the 4:2 priority-encoder convention.
REQ-013 With RR=1, a W-bit pointer ptr SHALL be kept; the search order SHALL be ptr, ptr+1, ..., N-1, 0, ..., ptr-1, and the first asserted bit SHALL win.
REQ-014 With RR=1, after a grant to index k, ptr SHALL become k+1; it SHALL wrap to 0 when k = N-1, including for non-power-of-two N.
REQ-015 With en=1 and req all zero, gnt SHALL be 0, gnt_idx SHALL be 0, gnt_valid SHALL be 0, and ptr SHALL be unchanged.
REQ-016 With en=0, gnt, gnt_idx, gnt_valid and ptr SHALL hold their values regardless of req.
REQ-017 The FSM SHALL have states IDLE (gnt_valid=0) and GRANT (gnt_valid=1), plus LOCK per REQ-023.
REQ-018 FSM transitions SHALL be: IDLE->GRANT on en & |req; GRANT->IDLE on en & ~|req; GRANT->GRANT on en & |req with re-arbitration.
REQ-019 gnt SHALL always equal 1<<gnt_idx when gnt_valid=1, and be zero otherwise; the bench SHALL assert this every cycle.

Reset
REQ-020 When rst=1 at an edge, it SHALL override en and req, and SHALL set gnt=0, gnt_idx=0, gnt_valid=0, ptr=0 and state=IDLE.
REQ-021 Reset asserted mid-grant SHALL discard the current grant and lock; the first arbitration after reset SHALL start from index 0 in RR mode.

Configuration
REQ-022 Macro PRIORITY_ARBITER_LOCK_EN SHALL select grant locking.
REQ-023 With PRIORITY_ARBITER_LOCK_EN defined, when gnt_valid=1, en=1 and req[gnt_idx]=1, the grant SHALL be held (state LOCK) and ptr SHALL not advance.
REQ-024 With PRIORITY_ARBITER_LOCK_EN defined, when the locked requester drops, normal arbitration SHALL occur at that same edge.
REQ-025 With PRIORITY_ARBITER_LOCK_EN undefined, the LOCK state SHALL not exist, and every en=1 edge SHALL re-arbitrate per REQ-012..REQ-014.

Structure
REQ-026 Package priority_arbiter_pkg SHALL hold MODE_FIXED=0, MODE_RR=1 and the FSM state enum (IDLE, GRANT, LOCK).
REQ-027 The combinational search SHALL be one sub-module, prio_pick (inputs: req, start index; outputs: found, index), instantiated once; the top SHALL hold only registers and the FSM.

Verification (N=4 unless stated)
REQ-028 rst=1 with req=4'b1111, en=1 -> after the edge gnt=0000, gnt_idx=0, gnt_valid=0.
REQ-029 RR=0, req=4'b0101, en=1 -> next cycle gnt=0100, gnt_idx=2, gnt_valid=1; then req=0000 -> gnt_valid=0.
REQ-030 RR=1, req=4'b1111 held 5 cycles, lock off -> gnt_idx sequence 0,1,2,3,0.
REQ-031 RR=1, grant to idx 2 (ptr=3), then req=4'b0011 -> gnt_idx=0 (wrap); with N=5, a grant to 4 -> ptr=0.
REQ-032 Grant at idx 1, then en=0 and req=0000 for 3 cycles -> outputs stay gnt_idx=1, gnt_valid=1; rst pulse -> all zeros, and the next RR grant with req=1111 -> idx 0.
REQ-033 With PRIORITY_ARBITER_LOCK_EN, RR=1, req=1111 -> gnt_idx stays 0; drop req[0] -> gnt_idx=1 on the next edge.
